id_scoreboard: RTL and testbench

Parametrised hazard and forwarding scoreboard for the decode stage. It generalises the fixed EX/MEM forwarding and load-use stall logic to NSTAGE downstream stages with per-instruction result latency. It tracks every in-flight register write in a shift-register of stage slots. From that it tells decode, per source operand, which stage to forward from, or whether to stall. It sits beside the register file in ID and is driven by the decode controller and the EX flush logic.

---
 rtl/id_sb_pkg.sv | 42 ++++
 rtl/id_sb_match.sv | 45 ++++
 rtl/id_scoreboard.sv | 98 +++++++++
 tb/tb_id_scoreboard.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/id_sb_pkg.sv
// ----------------------------------------------------------------------------
// Module   : id_sb_pkg
// Purpose  : Shared types and constants for the ID-stage hazard scoreboard.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package id_sb_pkg;

   // Slot fields are sized for the largest supported configuration
   // (REG_AW <= 8, NSTAGE <= 7); narrower addresses are zero-extended.
   localparam int SB_ADDR_W = 8;
   localparam int SB_REM_W  = 3;

   localparam int FWD_RF  = 0;
   localparam int FWD_EX  = 1;
   localparam int FWD_MEM = 2;
   localparam int FWD_WB  = 3;

   localparam int LAT_ALU  = 1;
   localparam int LAT_LOAD = 2;

   typedef struct packed {
      logic                 valid;
      logic [SB_ADDR_W-1:0] waddr;
      logic [SB_REM_W-1:0]  rem;
   } slot_t;

   localparam int SLOT_W = $bits(slot_t);

   // Cycles left before the result becomes forwardable, given its latency.
   function automatic logic [SB_REM_W-1:0] lat_to_rem(input int lat, input int nstage);
      int c;
      c = lat;
      if (c < 1)      c = 1;
      if (c > nstage) c = nstage;
      return SB_REM_W'(c - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/id_sb_match.sv
// ----------------------------------------------------------------------------
// Module   : id_sb_match
// Purpose  : Youngest-first match of one source operand against the slots.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module id_sb_match
   import id_sb_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int NSTAGE = 3,
   parameter int SW     = 2
) (
   input  logic [NSTAGE*SLOT_W-1:0] slots_i,
   input  logic [REG_AW-1:0]        addr_i,
   input  logic                     used_i,
   output logic                     hit_o,
   output logic                     blocked_o,
   output logic [SW-1:0]            stage_o
);

   slot_t [NSTAGE:1] w_slots;
   logic             w_cand;

   assign w_slots = slots_i;
   assign w_cand  = used_i && (addr_i != '0);

   // Scan oldest to youngest so the youngest matching producer wins.
   always_comb begin
      hit_o     = 1'b0;
      blocked_o = 1'b0;
      stage_o   = '0;
      for (int k = NSTAGE; k >= 1; k--) begin
         if (w_cand && w_slots[k].valid && (w_slots[k].waddr == SB_ADDR_W'(addr_i))) begin
            hit_o     = 1'b1;
            blocked_o = (w_slots[k].rem != '0);
            stage_o   = SW'(k);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/id_scoreboard.sv
// ----------------------------------------------------------------------------
// Module   : id_scoreboard
// Purpose  : Decode-stage hazard/forwarding scoreboard over NSTAGE stages.
//            Define ID_SB_STATS_EN to add the stall_cycles_o counter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module id_scoreboard
   import id_sb_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int NSTAGE = 3,
   parameter int SW     = $clog2(NSTAGE + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid_i,
   input  logic              issue_we_i,
   input  logic [REG_AW-1:0] issue_waddr_i,
   input  logic [SW-1:0]     issue_lat_i,
   input  logic              flush_ex_i,
   input  logic [REG_AW-1:0] rs_addr_i,
   input  logic [REG_AW-1:0] rt_addr_i,
   input  logic              rs_used_i,
   input  logic              rt_used_i,
   output logic              stall_o,
   output logic [SW-1:0]     rs_fwd_o,
   output logic [SW-1:0]     rt_fwd_o
`ifdef ID_SB_STATS_EN
   ,
   output logic [31:0]       stall_cycles_o
`endif
);

   slot_t [NSTAGE:1] slots_q;
   slot_t [NSTAGE:1] slots_d;

   logic          w_rs_hit, w_rs_blk, w_rt_hit, w_rt_blk;
   logic [SW-1:0] w_rs_stage, w_rt_stage;
   logic          w_accept;

   id_sb_match #(.REG_AW(REG_AW), .NSTAGE(NSTAGE), .SW(SW)) u_match_rs (
      .slots_i   (slots_q),
      .addr_i    (rs_addr_i),
      .used_i    (rs_used_i),
      .hit_o     (w_rs_hit),
      .blocked_o (w_rs_blk),
      .stage_o   (w_rs_stage)
   );

   id_sb_match #(.REG_AW(REG_AW), .NSTAGE(NSTAGE), .SW(SW)) u_match_rt (
      .slots_i   (slots_q),
      .addr_i    (rt_addr_i),
      .used_i    (rt_used_i),
      .hit_o     (w_rt_hit),
      .blocked_o (w_rt_blk),
      .stage_o   (w_rt_stage)
   );

   assign stall_o  = w_rs_blk | w_rt_blk;
   assign rs_fwd_o = (w_rs_hit && !w_rs_blk) ? w_rs_stage : SW'(FWD_RF);
   assign rt_fwd_o = (w_rt_hit && !w_rt_blk) ? w_rt_stage : SW'(FWD_RF);

   // A stalled issue becomes a bubble; decode presents it again next cycle.
   assign w_accept = issue_valid_i && !stall_o && issue_we_i && (issue_waddr_i != '0);

   always_comb begin
      slots_d          = '0;
      slots_d[1].valid = w_accept;
      slots_d[1].waddr = SB_ADDR_W'(issue_waddr_i);
      slots_d[1].rem   = lat_to_rem(int'(issue_lat_i), NSTAGE);
      for (int k = 2; k <= NSTAGE; k++) begin
         slots_d[k]     = slots_q[k-1];
         slots_d[k].rem = (slots_q[k-1].rem == '0) ? '0 : slots_q[k-1].rem - SB_REM_W'(1);
      end
      slots_d[2].valid = slots_q[1].valid && !flush_ex_i;
   end

   always_ff @(posedge clk) begin
      if (rst) slots_q <= '0;
      else     slots_q <= slots_d;
   end

`ifdef ID_SB_STATS_EN
   logic [31:0] stall_cycles_q;

   always_ff @(posedge clk) begin
      if (rst)          stall_cycles_q <= '0;
      else if (stall_o) stall_cycles_q <= stall_cycles_q + 32'd1;
   end

   assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_scoreboard.sv
// ----------------------------------------------------------------------------
// Module   : tb_id_scoreboard
// Purpose  : Directed scoreboard bench for id_scoreboard (NSTAGE=3).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_id_scoreboard;
   import id_sb_pkg::*;

   localparam int NSTAGE = 3;
   localparam int SW     = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          issue_valid_i = 1'b0, issue_we_i = 1'b0, flush_ex_i = 1'b0;
   logic [4:0]    issue_waddr_i = '0, rs_addr_i = '0, rt_addr_i = '0;
   logic [SW-1:0] issue_lat_i = '0;
   logic          rs_used_i = 1'b0, rt_used_i = 1'b0;
   logic          stall_o;
   logic [SW-1:0] rs_fwd_o, rt_fwd_o;
`ifdef ID_SB_STATS_EN
   logic [31:0]   stall_cycles_o;
`endif

   id_scoreboard #(.REG_AW(5), .NSTAGE(NSTAGE)) dut (
      .clk           (clk),
      .rst           (rst),
      .issue_valid_i (issue_valid_i),
      .issue_we_i    (issue_we_i),
      .issue_waddr_i (issue_waddr_i),
      .issue_lat_i   (issue_lat_i),
      .flush_ex_i    (flush_ex_i),
      .rs_addr_i     (rs_addr_i),
      .rt_addr_i     (rt_addr_i),
      .rs_used_i     (rs_used_i),
      .rt_used_i     (rt_used_i),
      .stall_o       (stall_o),
      .rs_fwd_o      (rs_fwd_o),
      .rt_fwd_o      (rt_fwd_o)
`ifdef ID_SB_STATS_EN
      ,
      .stall_cycles_o(stall_cycles_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int            cyc;
      bit            chk_out;
      bit            chk_fwd;
      bit            e_stall;
      logic [SW-1:0] e_rs;
      logic [SW-1:0] e_rt;
      bit            chk_stats;
      int            e_stats;
      string         name;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: retire every expectation scheduled for the current cycle.
   always @(negedge clk) begin
      while (q.size() != 0 && q[0].cyc <= cyc) begin
         mon_e = q.pop_front();
         if (mon_e.cyc != cyc) begin
            cmp({mon_e.name, "_late"}, 32'(cyc), 32'(mon_e.cyc));
         end else begin
            if (mon_e.chk_out) begin
               cmp({mon_e.name, "_stall"}, 32'(stall_o), 32'(mon_e.e_stall));
               if (mon_e.chk_fwd) begin
                  cmp({mon_e.name, "_rs_fwd"}, 32'(rs_fwd_o), 32'(mon_e.e_rs));
                  cmp({mon_e.name, "_rt_fwd"}, 32'(rt_fwd_o), 32'(mon_e.e_rt));
               end
            end
`ifdef ID_SB_STATS_EN
            if (mon_e.chk_stats)
               cmp({mon_e.name, "_stall_cycles"}, stall_cycles_o, 32'(mon_e.e_stats));
`endif
         end
      end
   end

   task automatic exp_stats(input int v, input string nm);
      exp_t e;
      e = '{cyc: cyc, chk_out: 1'b0, chk_fwd: 1'b0, e_stall: 1'b0, e_rs: '0, e_rt: '0,
            chk_stats: 1'b1, e_stats: v, name: nm};
      q.push_back(e);
   endtask

   // One decode cycle: drive inputs, optionally schedule the expected outputs.
   task automatic step(input bit iv, input logic [4:0] wa, input logic [SW-1:0] lat, input bit fl,
                       input logic [4:0] rsa, input bit rsu, input logic [4:0] rta, input bit rtu,
                       input bit chk, input bit est, input logic [SW-1:0] ers,
                       input logic [SW-1:0] ert, input string nm);
      exp_t e;
      issue_valid_i = iv;
      issue_we_i    = iv;
      issue_waddr_i = wa;
      issue_lat_i   = lat;
      flush_ex_i    = fl;
      rs_addr_i     = rsa;
      rs_used_i     = rsu;
      rt_addr_i     = rta;
      rt_used_i     = rtu;
      if (chk) begin
         e = '{cyc: cyc, chk_out: 1'b1, chk_fwd: !est, e_stall: est, e_rs: ers, e_rt: ert,
               chk_stats: 1'b0, e_stats: 0, name: nm};
         q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
`ifdef ID_SB_STATS_EN
      exp_stats(0, "reset");
`endif
      step(0, 0, 0, 0,  3, 1,  3, 1,  1, 0, 0, 0, "reset");
      rst = 1'b0;

      // ALU producer walking EX -> MEM -> WB -> gone
      step(1, 3, 2'(LAT_ALU), 0,  0, 0,  0, 0,  0, 0, 0, 0, "");
      step(0, 0, 0, 0,  3, 1,  0, 0,  1, 0, 1, 0, "ex_fwd");
      step(0, 0, 0, 0,  3, 1,  0, 0,  1, 0, 2, 0, "mem_fwd");
      step(0, 0, 0, 0,  3, 1,  0, 0,  1, 0, 3, 0, "wb_fwd");
      step(0, 0, 0, 0,  3, 1,  0, 0,  1, 0, 0, 0, "wb_gone");

      // Load-use: one stall, then MEM forward; stalled issue enters once
      step(1, 5, 2'(LAT_LOAD), 0,  0, 0,  0, 0,  0, 0, 0, 0, "");
      step(1, 6, 2'(LAT_ALU), 0,  0, 0,  5, 1,  1, 1, 0, 0, "load_use_stall");
      step(1, 6, 2'(LAT_ALU), 0,  6, 1,  5, 1,  1, 0, 0, 2, "load_use_fwd");
      step(0, 0, 0, 0,  6, 1,  0, 0,  1, 0, 1, 0, "reissue_once");

      // Youngest producer shadows older load
      step(1, 7, 2'(LAT_LOAD), 0,  0, 0,  0, 0,  0, 0, 0, 0, "");
      step(1, 7, 2'(LAT_ALU), 0,  0, 0,  0, 0,  0, 0, 0, 0, "");
      step(0, 0, 0, 0,  7, 1,  7, 1,  1, 0, 1, 1, "youngest");

      // Flush squashes $9 while a same-cycle issue of $10 still enters
      step(1, 9, 2'(LAT_ALU), 0,  0, 0,  0, 0,  0, 0, 0, 0, "");
      step(1, 10, 2'(LAT_ALU), 1,  0, 0,  0, 0,  0, 0, 0, 0, "");
      step(0, 0, 0, 0,  9, 1,  10, 1,  1, 0, 0, 1, "flush");

      // $0 never tracked; unused operands never stall
      step(1, 0, 2'(LAT_ALU), 0,  0, 0,  0, 0,  0, 0, 0, 0, "");
      step(1, 4, 2'(LAT_LOAD), 0,  0, 1,  0, 0,  1, 0, 0, 0, "reg0_src");
      step(0, 0, 0, 0,  4, 0,  0, 1,  1, 0, 0, 0, "unused_src");
      step(0, 0, 0, 0,  4, 1,  0, 0,  1, 0, 2, 0, "lw_mem_fwd");

      // lat=3 gives two stalls; lat=0 clamps to 1
      step(1, 8, 2'd3, 0,  0, 0,  0, 0,  0, 0, 0, 0, "");
      step(0, 0, 0, 0,  8, 1,  0, 0,  1, 1, 0, 0, "lat3_stall1");
      step(0, 0, 0, 0,  8, 1,  0, 0,  1, 1, 0, 0, "lat3_stall2");
      step(0, 0, 0, 0,  8, 1,  0, 0,  1, 0, 3, 0, "lat3_fwd");
      step(1, 11, 2'd0, 0,  0, 0,  0, 0,  0, 0, 0, 0, "");
      step(0, 0, 0, 0,  11, 1,  0, 0,  1, 0, 1, 0, "lat0_clamp");

      // Mid-operation reset discards an in-flight load
`ifdef ID_SB_STATS_EN
      exp_stats(3, "three_stalls");
`endif
      step(1, 12, 2'(LAT_LOAD), 0,  0, 0,  0, 0,  0, 0, 0, 0, "");
      rst = 1'b1;
      step(0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, "");
      rst = 1'b0;
`ifdef ID_SB_STATS_EN
      exp_stats(0, "stats_reset");
`endif
      step(0, 0, 0, 0,  12, 1,  12, 1,  1, 0, 0, 0, "reset_flush");

      step(0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, "");
      step(0, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, "");
      cmp("queue_drained", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
